fibo_bus_ring: RTL and testbench



---
 rtl/fibo_pkg.sv | 18 +
 rtl/fibo_bus_ring_if.sv | 25 ++
 rtl/fibo_node.sv | 30 +++
 rtl/fibo_bus_ring.sv | 86 ++++++++
 tb/tb_fibo_bus_ring.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/fibo_pkg.sv
// Shared definitions for the N-bonacci bus ring: sequencer states and
// the one-hot node-enable helper.
package fibo_pkg;

    localparam int MAX_NODES = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Returns a single set bit at position idx when en is high, else all zeros.
    function automatic logic [MAX_NODES-1:0] onehot_en(input logic [2:0] idx, input logic en);
        onehot_en = en ? (MAX_NODES'(1) << idx) : '0;
    endfunction

endpackage

// File: rtl/fibo_bus_ring_if.sv
// Control and sequence-output bundle of the bus ring; the ring is the slave,
// whoever issues start/hold is the master.
interface fibo_bus_ring_if #(
    parameter int WIDTH = 32,
    parameter int NODES = 2
);
    logic                     start;
    logic                     hold;
    logic [WIDTH-1:0]         bus_out;
    logic                     bus_valid;
    logic [$clog2(NODES)-1:0] active_node;
    logic [15:0]              term_count;
    logic                     overflow;
    logic                     done;

    modport master (
        output start, hold,
        input  bus_out, bus_valid, active_node, term_count, overflow, done
    );

    modport slave (
        input  start, hold,
        output bus_out, bus_valid, active_node, term_count, overflow, done
    );
endinterface

// File: rtl/fibo_node.sv
// One accumulator on the shared tri-state bus: drives its value when sending,
// adds the bus value into itself when receiving.
module fibo_node #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_val,
    input  logic             enable_send,
    input  logic             enable_receive,
    inout  tri   [WIDTH-1:0] bus,
    output logic             carry
);
    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   sum;

    assign bus   = enable_send ? acc : {WIDTH{1'bz}};
    assign sum   = {1'b0, acc} + {1'b0, bus};
    assign carry = enable_receive & sum[WIDTH];

    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (load)
            acc <= seed_val;
        else if (enable_receive)
            acc <= sum[WIDTH-1:0];
    end
endmodule

// File: rtl/fibo_bus_ring.sv
// NODES accumulators on one tri-state bus, sequenced round-robin so the bus
// carries the N-bonacci sequence; adds seeding, hold, term limit and overflow stop.
module fibo_bus_ring
    import fibo_pkg::*;
#(
    parameter int              WIDTH       = 32,
    parameter int              NODES       = 2,
    parameter longint unsigned SEED        = 1,
    parameter int              MAX_TERMS   = 1000,
    parameter bit              STOP_ON_OVF = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    fibo_bus_ring_if.slave  bus_if
);
    localparam int AW = $clog2(NODES);

    state_t           state_q, state_d;
    logic [AW-1:0]    active_q;
    logic [15:0]      term_q;
    logic             ovf_q;

    tri   [WIDTH-1:0] bus_int;
    logic [NODES-1:0] send_en, recv_en, carry;
    logic             run_go, ovf_now, last_term;

    assign run_go    = (state_q == S_RUN) && !bus_if.hold;
    assign send_en   = NODES'(onehot_en(3'(active_q), run_go));
    assign recv_en   = run_go ? ~send_en : '0;
    assign ovf_now   = |carry;
    assign last_term = (term_q + 16'd1) == 16'(MAX_TERMS);

    for (genvar i = 0; i < NODES; i++) begin : g_node
        localparam logic [WIDTH-1:0] NODE_SEED = (i == 0) ? WIDTH'(SEED) : '0;
        fibo_node #(.WIDTH(WIDTH)) u_node (
            .clk            (clk),
            .rst            (rst),
            .load           (bus_if.start),
            .seed_val       (NODE_SEED),
            .enable_send    (send_en[i]),
            .enable_receive (recv_en[i]),
            .bus            (bus_int),
            .carry          (carry[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (run_go && (last_term || (STOP_ON_OVF && ovf_now))) state_d = S_DONE;
            default: state_d = state_q;
        endcase
        if (bus_if.start)
            state_d = S_RUN;
    end

    always_ff @(posedge clk) begin
        if (rst || bus_if.start) begin
            active_q <= '0;
            term_q   <= '0;
            ovf_q    <= 1'b0;
        end else if (run_go) begin
            // NODES need not be a power of two, so wrap explicitly
            active_q <= (active_q == AW'(NODES - 1)) ? '0 : active_q + AW'(1);
            term_q   <= term_q + 16'd1;
            if (ovf_now)
                ovf_q <= 1'b1;
        end
    end

    assign bus_if.bus_out     = run_go ? bus_int : '0;
    assign bus_if.bus_valid   = run_go;
    assign bus_if.active_node = active_q;
    assign bus_if.term_count  = term_q;
    assign bus_if.overflow    = ovf_q;
    assign bus_if.done        = (state_q == S_DONE);

    bus_single_driver: assert property (@(posedge clk) disable iff (rst) run_go |-> $onehot(send_en));
endmodule

// File: tb/tb_fibo_bus_ring.sv
// Scoreboard bench for fibo_bus_ring: four configurations, expected terms queued
// at stimulus time and checked by per-instance monitors whenever bus_valid is high.
module tb_fibo_bus_ring;
    typedef struct {
        longint unsigned val;
        int              an;
        int              tc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;

    exp_t qa[$], qb[$], qc[$], qd[$];
    exp_t ea, eb, ec, ed;

    int unsigned fib  [13] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
    int unsigned trib [8]  = '{1, 1, 2, 4, 7, 13, 24, 44};

    always #5 clk = ~clk;

    fibo_bus_ring_if #(.WIDTH(32), .NODES(2)) ifa ();
    fibo_bus_ring_if #(.WIDTH(16), .NODES(3)) ifb ();
    fibo_bus_ring_if #(.WIDTH(8),  .NODES(2)) ifc ();
    fibo_bus_ring_if #(.WIDTH(8),  .NODES(2)) ifd ();

    fibo_bus_ring #(.WIDTH(32), .NODES(2), .SEED(1), .MAX_TERMS(1000), .STOP_ON_OVF(1'b1))
        dut_a (.clk(clk), .rst(rst), .bus_if(ifa));
    fibo_bus_ring #(.WIDTH(16), .NODES(3), .SEED(1), .MAX_TERMS(1000), .STOP_ON_OVF(1'b1))
        dut_b (.clk(clk), .rst(rst), .bus_if(ifb));
    fibo_bus_ring #(.WIDTH(8),  .NODES(2), .SEED(1), .MAX_TERMS(1000), .STOP_ON_OVF(1'b1))
        dut_c (.clk(clk), .rst(rst), .bus_if(ifc));
    fibo_bus_ring #(.WIDTH(8),  .NODES(2), .SEED(1), .MAX_TERMS(4),    .STOP_ON_OVF(1'b1))
        dut_d (.clk(clk), .rst(rst), .bus_if(ifd));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic unexp(input string nm, input logic [63:0] v);
        compared++;
        mismatched++;
        $display("FAIL %s.unexpected_term: got term %0d expected no valid term", nm, v);
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Monitors: value and driver index at mid-cycle, term_count just after the consuming edge
    always @(negedge clk) if (ifa.bus_valid === 1'b1) begin
        if (qa.size() == 0) unexp("A", 64'(ifa.bus_out));
        else begin
            ea = qa.pop_front();
            chk("A.term", 64'(ifa.bus_out), ea.val);
            chk("A.node", 64'(ifa.active_node), 64'(ea.an));
            @(posedge clk); #1;
            chk("A.count", 64'(ifa.term_count), 64'(ea.tc));
        end
    end

    always @(negedge clk) if (ifb.bus_valid === 1'b1) begin
        if (qb.size() == 0) unexp("B", 64'(ifb.bus_out));
        else begin
            eb = qb.pop_front();
            chk("B.term", 64'(ifb.bus_out), eb.val);
            chk("B.node", 64'(ifb.active_node), 64'(eb.an));
            @(posedge clk); #1;
            chk("B.count", 64'(ifb.term_count), 64'(eb.tc));
        end
    end

    always @(negedge clk) if (ifc.bus_valid === 1'b1) begin
        if (qc.size() == 0) unexp("C", 64'(ifc.bus_out));
        else begin
            ec = qc.pop_front();
            chk("C.term", 64'(ifc.bus_out), ec.val);
            chk("C.node", 64'(ifc.active_node), 64'(ec.an));
            @(posedge clk); #1;
            chk("C.count", 64'(ifc.term_count), 64'(ec.tc));
        end
    end

    always @(negedge clk) if (ifd.bus_valid === 1'b1) begin
        if (qd.size() == 0) unexp("D", 64'(ifd.bus_out));
        else begin
            ed = qd.pop_front();
            chk("D.term", 64'(ifd.bus_out), ed.val);
            chk("D.node", 64'(ifd.active_node), 64'(ed.an));
            @(posedge clk); #1;
            chk("D.count", 64'(ifd.term_count), 64'(ed.tc));
        end
    end

    initial begin
        {ifa.start, ifa.hold, ifb.start, ifb.hold} = '0;
        {ifc.start, ifc.hold, ifd.start, ifd.hold} = '0;
        tick(2);
        rst = 1'b0;
        chk("A.rst.bus_out",  64'(ifa.bus_out),     0);
        chk("A.rst.valid",    64'(ifa.bus_valid),   0);
        chk("A.rst.node",     64'(ifa.active_node), 0);
        chk("A.rst.count",    64'(ifa.term_count),  0);
        chk("A.rst.overflow", 64'(ifa.overflow),    0);
        chk("A.rst.done",     64'(ifa.done),        0);
        tick(2);
        chk("A.idle.valid", 64'(ifa.bus_valid), 0);

        // Tribonacci, then freeze with hold so nothing further is emitted
        for (int k = 0; k < 8; k++) qb.push_back('{trib[k], k % 3, k + 1});
        ifb.start = 1'b1; tick(); ifb.start = 1'b0;
        tick(8);
        ifb.hold = 1'b1;
        tick(2);
        chk("B.hold.count", 64'(ifb.term_count), 8);

        // 8-bit Fibonacci runs into carry-out after term 233
        for (int k = 0; k < 13; k++) qc.push_back('{fib[k], k % 2, k + 1});
        ifc.start = 1'b1; tick(); ifc.start = 1'b0;
        tick(13);
        chk("C.ovf.overflow", 64'(ifc.overflow),   1);
        chk("C.ovf.done",     64'(ifc.done),       1);
        chk("C.ovf.valid",    64'(ifc.bus_valid),  0);
        chk("C.ovf.count",    64'(ifc.term_count), 13);
        tick(2);
        chk("C.ovf.sticky",   64'(ifc.overflow),   1);
        for (int k = 0; k < 3; k++) qc.push_back('{fib[k], k % 2, k + 1});
        ifc.start = 1'b1; tick(); ifc.start = 1'b0;
        chk("C.restart.overflow", 64'(ifc.overflow), 0);
        chk("C.restart.done",     64'(ifc.done),     0);
        tick(3);
        ifc.hold = 1'b1;

        // Term limit of 4, restart from DONE, then restart mid-run
        for (int k = 0; k < 4; k++) qd.push_back('{fib[k], k % 2, k + 1});
        ifd.start = 1'b1; tick(); ifd.start = 1'b0;
        tick(4);
        chk("D.max.done",  64'(ifd.done),       1);
        chk("D.max.count", 64'(ifd.term_count), 4);
        chk("D.max.valid", 64'(ifd.bus_valid),  0);
        tick(2);
        chk("D.max.frozen", 64'(ifd.term_count), 4);
        for (int k = 0; k < 2; k++) qd.push_back('{fib[k], k % 2, k + 1});
        ifd.start = 1'b1; tick(); ifd.start = 1'b0;
        tick(2);
        qd.push_back('{2, 0, 0});
        qd.push_back('{1, 0, 1});
        qd.push_back('{1, 1, 2});
        ifd.start = 1'b1; tick(); ifd.start = 1'b0;
        tick(2);
        ifd.hold = 1'b1;

        // Fibonacci with a 3-cycle hold after term 5, then rst+start mid-run
        for (int k = 0; k < 5; k++) qa.push_back('{fib[k], k % 2, k + 1});
        ifa.start = 1'b1; tick(); ifa.start = 1'b0;
        tick(5);
        ifa.hold = 1'b1;
        tick(3);
        chk("A.hold.valid", 64'(ifa.bus_valid),  0);
        chk("A.hold.count", 64'(ifa.term_count), 5);
        chk("A.hold.bus",   64'(ifa.bus_out),    0);
        for (int k = 5; k < 8; k++) qa.push_back('{fib[k], k % 2, k + 1});
        ifa.hold = 1'b0;
        tick(3);
        qa.push_back('{34, 0, 0});
        rst = 1'b1; ifa.start = 1'b1; tick();
        rst = 1'b0; ifa.start = 1'b0;
        chk("A.rstwin.valid", 64'(ifa.bus_valid),   0);
        chk("A.rstwin.bus",   64'(ifa.bus_out),     0);
        chk("A.rstwin.node",  64'(ifa.active_node), 0);
        chk("A.rstwin.count", 64'(ifa.term_count),  0);
        chk("A.rstwin.done",  64'(ifa.done),        0);
        tick(3);
        chk("A.rstwin.idle", 64'(ifa.bus_valid), 0);

        chk("A.queue_left", 64'(qa.size()), 0);
        chk("B.queue_left", 64'(qb.size()), 0);
        chk("C.queue_left", 64'(qc.size()), 0);
        chk("D.queue_left", 64'(qd.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
